modexp_ctrl: RTL and testbench
==============================

# modexp_ctrl

Modular-exponentiation sequencer for the RSA decryption path: computes m = c^d mod n by left-to-right square-and-multiply. It sits directly upstream of the restoring divider `div`, which it owns as a sub-module. It forms each W×W product, issues it to `div` as the dividend with n as the divisor, and consumes the remainder as the reduced intermediate. One result is produced per accepted start; there is no pipelining across requests.

## Interface
- `W`, default 8: operand width in bits (c, d, n, m).
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request pulse; sampled only in IDLE.
- `c`  in  W: ciphertext; sampled with start.
- `d`  in  W: private exponent; sampled with start.
- `n`  in  W: modulus; sampled with start.
- `m`  out  W: result; valid while `done`=1, held until the next accepted start.
- `done`  out  1: one-cycle result pulse.
- `err`  out  1: n==0 flag; valid with `done`, held like `m`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Reset values: `m`=0, `done`=0, `err`=0, `busy`=0, state=IDLE, divider start=0. Operand registers are cleared.
- IDLE: on `start`=1, latch c, d and n.
  - If n==0: stay in IDLE, then in the next cycle drive `done`=1, `err`=1, `m`=0. The divider is not used.
  - Otherwise: acc=1, bit index k=W-1, go to ISSUE with op=PRE.
- Op sequence: PRE (base = c mod n, dividend {W'b0,c}); then for k=W-1 down to 0: SQR (acc = acc·acc mod n), then MUL (acc = acc·base mod n) only if d[k]=1.
- The total number of ops is N = 1 + W + popcount(d). All W squarings always execute, which keeps latency data-dependent only on popcount(d).
- ISSUE (1 cycle): drive divider start=1, x = 2W-bit product (combinational from registered acc/base), y = {W'b0,n}. Go to WAIT.
- WAIT: hold divider start=0. Wait for divider done=1, which is first visible 2W+1 cycles after ISSUE.
  - On that cycle, capture r[W-1:0] into base (PRE) or acc (SQR/MUL).
  - Then select the next op and go to ISSUE, or, after the final op, go to IDLE with `m`=acc, `err`=0 and a `done` pulse.
- Divider done is qualified only in WAIT. ISSUE's start edge clears it, so a stale or undefined divider `done` (the divider has no reset) is never sampled.
- Width rule: operands are always < n (except c, which PRE reduces), so the product is < 2^(2W). `div` dbz and ovf cannot occur (n≠0 and FBITS=0) and are ignored.
- n==1 yields m=0. d==0 yields m=1 mod n.
- `start` while `busy`=1 is ignored with no side effect. `start` in the `done` cycle (state IDLE) is accepted.
- Reset mid-operation: immediately return to IDLE with reset values. No `done` is produced for the aborted request.

## Timing
- An op occupies exactly 2W+2 cycles (1 ISSUE + 2W+1 WAIT).
- With the start sampled in cycle 0, `done` is high in cycle 1 + N·(2W+2).
- For n==0, `done` is high in cycle 1.
- `busy` is high from cycle 1 through the cycle before `done`.
- Back-to-back: a start accepted in the `done` cycle restarts the count from that cycle.

## Structure
- Shared package `rsa_pkg`: state encoding (IDLE, ISSUE, WAIT), op encoding (PRE, SQR, MUL), and the default key width constant.
- One sub-module: `div` instantiated with WIDTH=2W and FBITS=0. The controller, product multiplier and operand registers are local.

## Test plan
- W=8, c=31, d=7, n=33 -> m=4, err=0, `done` in cycle 217 (N=12), single-cycle pulse.
- c=5, d=0, n=33 -> m=1 in cycle 163. Repeat with n=1, d=7 -> m=0 in cycle 217.
- c=200, d=1, n=33 (c ≥ n) -> m=2 in cycle 181. Then c=255, d=255, n=251 -> m=20 in cycle 307.
- n=0, c=7, d=3 -> `done`=1, err=1, m=0 in cycle 1. The divider start is never asserted.
- Start the c=31/d=7/n=33 request, pulse `start` with other operands at cycle 40, then check the result -> pulse ignored, m=4 in cycle 217. Issue the next start in the `done` cycle -> it is accepted.
- Drive `rst_n` low at cycle 50 of a request -> outputs go to reset values asynchronously and no `done` follows. Restart c=31/d=7/n=33 -> m=4 at cycle 217 relative to the new start.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared encodings for the RSA modular-exponentiation path.
package rsa_pkg;

  localparam int KEY_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    PRE,
    SQR,
    MUL
  } op_t;

endpackage

// File: rtl/modexp_ctrl_if.sv
// Request/result bus of the modexp sequencer.
interface modexp_ctrl_if #(
  parameter int W = rsa_pkg::KEY_W
);
  logic         start;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [W-1:0] n;
  logic [W-1:0] m;
  logic         done;
  logic         err;
  logic         busy;

  modport master (output start, c, d, n, input m, done, err, busy);
  modport slave  (input start, c, d, n, output m, done, err, busy);
endinterface

// File: rtl/div.sv
// Restoring divider, one quotient bit per cycle. done rises WIDTH+FBITS
// cycles after the start edge and holds until the next start. No reset:
// the owner must only look at done after issuing a start.
module div #(
  parameter int WIDTH = 16,
  parameter int FBITS = 0
) (
  input  logic             clk,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);
  localparam int NB = WIDTH + FBITS;
  localparam int CW = $clog2(NB + 1);

  logic [NB-1:0]    qs;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] ys;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   sh;
  logic             ge;

  // trial subtraction of the shifted partial remainder
  always_comb begin
    sh = {rs, qs[NB-1]};
    ge = (sh >= {1'b0, ys});
  end

  // iterate one bit per cycle after a start
  always_ff @(posedge clk) begin
    if (start) begin
      qs   <= NB'(x) << FBITS;
      rs   <= '0;
      ys   <= y;
      cnt  <= '0;
      run  <= 1'b1;
      done <= 1'b0;
      dbz  <= (y == '0);
    end else if (run) begin
      if (ge) begin
        rs <= WIDTH'(sh - {1'b0, ys});
        qs <= {qs[NB-2:0], 1'b1};
      end else begin
        rs <= sh[WIDTH-1:0];
        qs <= {qs[NB-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (cnt == CW'(NB - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign q   = qs[WIDTH-1:0];
  assign r   = rs;
  assign ovf = ((qs >> WIDTH) != '0);
endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer: m = c^d mod n.
// Every reduction goes through the restoring divider; all W squarings
// always run so latency depends only on popcount(d).
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int W = KEY_W
) (
  input logic          clk,
  input logic          rst_n,
  modexp_ctrl_if.slave bus
);
  localparam int KW = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  op_t            op;
  logic [W-1:0]   c_r, d_r, n_r;
  logic [W-1:0]   acc, base;
  logic [KW-1:0]  k;
  logic [W-1:0]   m_r;
  logic           done_r, err_r, busy_r;

  logic           dv_start;
  logic [2*W-1:0] dv_x, dv_y, dv_q, dv_r;
  logic           dv_done, dv_dbz, dv_ovf;
  logic [W-1:0]   r_lo;
  logic           last, fin;
  logic           unused_div;

  // operands for the current op, from registered acc/base
  always_comb begin
    dv_x = '0;
    case (op)
      PRE:     dv_x = (2*W)'(c_r);
      SQR:     dv_x = (2*W)'(acc) * (2*W)'(acc);
      default: dv_x = (2*W)'(acc) * (2*W)'(base);
    endcase
    dv_y = (2*W)'(n_r);
    r_lo = dv_r[W-1:0];
    last = (k == '0);
    fin  = 1'b0;
    if (state == WAIT && dv_done) begin
      case (op)
        SQR:     fin = !d_r[k] && last;
        MUL:     fin = last;
        default: fin = 1'b0;
      endcase
    end
  end

  // n < 2^W and FBITS=0, so dbz/ovf/high bits never carry information
  assign unused_div = ^{dv_q, dv_dbz, dv_ovf, dv_r[2*W-1:W]};

  div #(.WIDTH(2*W), .FBITS(0)) u_div (
    .clk   (clk),
    .start (dv_start),
    .x     (dv_x),
    .y     (dv_y),
    .q     (dv_q),
    .r     (dv_r),
    .done  (dv_done),
    .dbz   (dv_dbz),
    .ovf   (dv_ovf)
  );

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= PRE;
      c_r      <= '0;
      d_r      <= '0;
      n_r      <= '0;
      acc      <= '0;
      base     <= '0;
      k        <= '0;
      dv_start <= 1'b0;
      m_r      <= '0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      dv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            c_r <= bus.c;
            d_r <= bus.d;
            n_r <= bus.n;
            if (bus.n == '0) begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
              m_r    <= '0;
            end else begin
              acc      <= W'(1);
              k        <= KW'(W - 1);
              op       <= PRE;
              state    <= ISSUE;
              dv_start <= 1'b1;
              busy_r   <= 1'b1;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (dv_done) begin
            case (op)
              PRE: begin
                base <= r_lo;
                op   <= SQR;
              end
              SQR: begin
                acc <= r_lo;
                if (d_r[k])     op <= MUL;
                else if (!last) k  <= k - 1'b1;
              end
              default: begin
                acc <= r_lo;
                op  <= SQR;
                if (!last) k <= k - 1'b1;
              end
            endcase
            if (fin) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              err_r  <= 1'b0;
              m_r    <= r_lo;
            end else begin
              state    <= ISSUE;
              dv_start <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m    = m_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl (W=8).
module tb_modexp_ctrl;
  localparam int W   = 8;
  localparam int OPC = 2*W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  modexp_ctrl_if #(.W(W)) bus ();
  modexp_ctrl #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] m;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;
  exp_t exp_q[$];

  function automatic int popc(input int v);
    int p = 0;
    for (int i = 0; i < W; i++) p += (v >> i) & 1;
    return p;
  endfunction

  // plain repeated multiplication, independent of the bit-serial order
  function automatic int ref_modexp(input int c, input int d, input int n);
    int r;
    if (n == 0) return 0;
    r = 1 % n;
    for (int i = 0; i < d; i++) r = (r * c) % n;
    return r;
  endfunction

  // called at a negedge; start is high for that one cycle (cycle 0)
  task automatic issue(input int c, input int d, input int n, input bit track);
    exp_t e;
    bus.c = W'(c);
    bus.d = W'(d);
    bus.n = W'(n);
    bus.start = 1'b1;
    if (track) begin
      e.m   = W'(ref_modexp(c, d, n));
      e.err = (n == 0);
      e.lat = (n == 0) ? 1 : 1 + (1 + W + popc(d)) * OPC;
      e.t0  = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // returns at the negedge where done is seen, or after the cycle budget
  task automatic wait_done(output bit got, output int at, output int busy_low,
                           output int ds_hi);
    got = 1'b0; at = 0; busy_low = 0; ds_hi = 0;
    for (int i = 0; i < 600; i++) begin
      if (dut.dv_start) ds_hi++;
      if (bus.done) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
      if (!bus.busy) busy_low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.c = '0; bus.d = '0; bus.n = '0;
    #1 rst_n = 1'b0;
    #11;
    total++;
    if ({bus.m, bus.done, bus.err, bus.busy} !== '0) begin
      bad++; $display("FAIL reset_outputs got m=%0d done=%b err=%b busy=%b want all 0",
                      bus.m, bus.done, bus.err, bus.busy);
    end
    total++;
    if (dut.dv_start !== 1'b0) begin
      bad++; $display("FAIL reset_divstart got %b want 0", dut.dv_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    int tc[5] = '{31, 5, 5, 200, 255};
    int td[5] = '{7, 0, 7, 1, 255};
    int tn[5] = '{33, 33, 1, 33, 251};
    bit got; int at, bl, ds;
    exp_t e;
    for (int v = 0; v < 5; v++) begin
      issue(tc[v], td[v], tn[v], 1'b1);
      wait_done(got, at, bl, ds);
      e = exp_q.pop_front();
      total++;
      if (!got) begin
        bad++; $display("FAIL vec%0d_timeout no done within budget want cycle %0d", v, e.lat);
        continue;
      end
      total++;
      if (bus.m !== e.m) begin
        bad++; $display("FAIL vec%0d_m got %0d want %0d", v, bus.m, e.m);
      end
      total++;
      if (bus.err !== e.err) begin
        bad++; $display("FAIL vec%0d_err got %b want %b", v, bus.err, e.err);
      end
      total++;
      if (at - e.t0 !== e.lat) begin
        bad++; $display("FAIL vec%0d_latency got %0d want %0d", v, at - e.t0, e.lat);
      end
      total++;
      if (bl !== 0) begin
        bad++; $display("FAIL vec%0d_busy got %0d low cycles want 0", v, bl);
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0 || bus.m !== e.m) begin
        bad++; $display("FAIL vec%0d_pulse got done=%b m=%0d want done=0 m=%0d",
                        v, bus.done, bus.m, e.m);
      end
    end
  endtask

  task automatic test_n_zero();
    bit got; int at, bl, ds;
    exp_t e;
    issue(7, 3, 0, 1'b1);
    wait_done(got, at, bl, ds);
    e = exp_q.pop_front();
    total++;
    if (!got || at - e.t0 !== e.lat) begin
      bad++; $display("FAIL nzero_latency got %0d (seen=%b) want %0d", at - e.t0, got, e.lat);
    end
    total++;
    if (bus.err !== 1'b1 || bus.m !== '0) begin
      bad++; $display("FAIL nzero_result got err=%b m=%0d want err=1 m=0", bus.err, bus.m);
    end
    total++;
    if (ds !== 0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL nzero_nodiv got divstarts=%0d busy=%b want 0 0", ds, bus.busy);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || dut.dv_start !== 1'b0) begin
      bad++; $display("FAIL nzero_pulse got done=%b divstart=%b want 0 0", bus.done, dut.dv_start);
    end
  endtask

  task automatic test_busy_ignore();
    bit got; int at, bl, ds;
    exp_t e;
    issue(31, 7, 33, 1'b1);
    repeat (39) @(negedge clk);
    issue(9, 9, 50, 1'b0);
    wait_done(got, at, bl, ds);
    e = exp_q.pop_front();
    total++;
    if (!got || bus.m !== e.m || at - e.t0 !== e.lat) begin
      bad++; $display("FAIL ignore_result got m=%0d at %0d (seen=%b) want m=%0d at %0d",
                      bus.m, at - e.t0, got, e.m, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit got; int at, bl, ds;
    exp_t e;
    issue(31, 7, 33, 1'b1);
    wait_done(got, at, bl, ds);
    e = exp_q.pop_front();
    total++;
    if (!got || bus.m !== e.m) begin
      bad++; $display("FAIL b2b_first got m=%0d (seen=%b) want %0d", bus.m, got, e.m);
    end
    issue(200, 1, 33, 1'b1);
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    wait_done(got, at, bl, ds);
    e = exp_q.pop_front();
    total++;
    if (!got || bus.m !== e.m || at - e.t0 !== e.lat) begin
      bad++; $display("FAIL b2b_second got m=%0d at %0d (seen=%b) want m=%0d at %0d",
                      bus.m, at - e.t0, got, e.m, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got; int at, bl, ds;
    int dcount;
    exp_t e;
    issue(31, 7, 33, 1'b1);
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.m, bus.done, bus.err, bus.busy} !== '0) begin
      bad++; $display("FAIL midreset_async got m=%0d done=%b err=%b busy=%b want all 0",
                      bus.m, bus.done, bus.err, bus.busy);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    total++;
    if (dcount !== 0) begin
      bad++; $display("FAIL midreset_nodone got %0d done cycles want 0", dcount);
    end
    issue(31, 7, 33, 1'b1);
    wait_done(got, at, bl, ds);
    e = exp_q.pop_front();
    total++;
    if (!got || bus.m !== e.m || at - e.t0 !== e.lat) begin
      bad++; $display("FAIL midreset_restart got m=%0d at %0d (seen=%b) want m=%0d at %0d",
                      bus.m, at - e.t0, got, e.m, e.lat);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_n_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
